// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle logic/arith/shift ops, an iterative shift-add multiplier,
// and an optional restoring divider enabled by defining ALU_MC_DIV_EN.
module alu_mc #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [WIDTH-1:0] src1_i,
    input  logic [WIDTH-1:0] src2_i,
    input  logic [3:0]       ctrl_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] result_o,
    output logic             zero_o
);
    localparam int CNT_W = $clog2(WIDTH) + 1;

`ifdef ALU_MC_DIV_EN
    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_MUL} state_t;
`endif

    state_t           r_state;
    logic             r_ready;
    logic             r_valid;
    logic [WIDTH-1:0] r_result;
    logic             r_zero;
    logic [CNT_W-1:0] r_cnt;
    // MUL: r_a multiplicand, r_b multiplier, r_acc partial product.
    // DIV: r_a divisor, r_b dividend/quotient, r_acc partial remainder.
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_acc;

    logic [WIDTH-1:0] w_sc_result;
    logic [WIDTH-1:0] w_mul_acc;
    logic             w_last;

    always_comb begin
        w_sc_result = '0;
        case (ctrl_i)
            4'd0:  w_sc_result = src1_i & src2_i;
            4'd1:  w_sc_result = src1_i | src2_i;
            4'd2:  w_sc_result = src1_i + src2_i;
            4'd3:  w_sc_result = src1_i - src2_i;
            4'd4:  w_sc_result = {{(WIDTH-1){1'b0}}, (src1_i < src2_i)};
            // Shifts by the full unsigned amount already yield zero for amounts >= WIDTH.
            4'd5:  w_sc_result = src2_i >> src1_i;
            4'd6:  w_sc_result = src2_i << src1_i;
            4'd7:  w_sc_result = {{(WIDTH-1){1'b0}}, ($signed(src1_i) < $signed(src2_i))};
            4'd14: w_sc_result = src2_i << (WIDTH / 2);
            default: w_sc_result = '0;
        endcase
    end

    assign w_mul_acc = r_acc + (r_b[0] ? r_a : '0);
    assign w_last    = (r_cnt == CNT_W'(1));

`ifdef ALU_MC_DIV_EN
    logic             r_rem_op;
    logic [WIDTH:0]   w_div_shift;
    logic             w_div_ge;
    logic [WIDTH-1:0] w_div_sub;
    logic [WIDTH-1:0] w_div_rem;
    logic [WIDTH-1:0] w_div_quo;

    // Restoring step; a zero divisor naturally gives all-ones quotient and remainder = dividend.
    assign w_div_shift = {r_acc, r_b[WIDTH-1]};
    assign w_div_ge    = (w_div_shift >= {1'b0, r_a});
    assign w_div_sub   = w_div_shift[WIDTH-1:0] - r_a;
    assign w_div_rem   = w_div_ge ? w_div_sub : w_div_shift[WIDTH-1:0];
    assign w_div_quo   = {r_b[WIDTH-2:0], w_div_ge};
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state  <= S_IDLE;
            r_ready  <= 1'b1;
            r_valid  <= 1'b0;
            r_result <= '0;
            r_zero   <= 1'b1;
            r_cnt    <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_acc    <= '0;
`ifdef ALU_MC_DIV_EN
            r_rem_op <= 1'b0;
`endif
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (valid_i) begin
                        if (ctrl_i == 4'd8) begin
                            r_a     <= src1_i;
                            r_b     <= src2_i;
                            r_acc   <= '0;
                            r_cnt   <= CNT_W'(WIDTH);
                            r_ready <= 1'b0;
                            r_state <= S_MUL;
`ifdef ALU_MC_DIV_EN
                        end else if (ctrl_i == 4'd9 || ctrl_i == 4'd10) begin
                            r_a      <= src2_i;
                            r_b      <= src1_i;
                            r_acc    <= '0;
                            r_rem_op <= (ctrl_i == 4'd10);
                            r_cnt    <= CNT_W'(WIDTH);
                            r_ready  <= 1'b0;
                            r_state  <= S_DIV;
`endif
                        end else begin
                            r_result <= w_sc_result;
                            r_zero   <= (w_sc_result == '0);
                            r_valid  <= 1'b1;
                        end
                    end
                end
                S_MUL: begin
                    r_acc <= w_mul_acc;
                    r_a   <= r_a << 1;
                    r_b   <= r_b >> 1;
                    r_cnt <= r_cnt - CNT_W'(1);
                    if (w_last) begin
                        r_result <= w_mul_acc;
                        r_zero   <= (w_mul_acc == '0);
                        r_valid  <= 1'b1;
                        r_ready  <= 1'b1;
                        r_state  <= S_IDLE;
                    end
                end
`ifdef ALU_MC_DIV_EN
                S_DIV: begin
                    r_acc <= w_div_rem;
                    r_b   <= w_div_quo;
                    r_cnt <= r_cnt - CNT_W'(1);
                    if (w_last) begin
                        r_result <= r_rem_op ? w_div_rem : w_div_quo;
                        r_zero   <= r_rem_op ? (w_div_rem == '0) : (w_div_quo == '0);
                        r_valid  <= 1'b1;
                        r_ready  <= 1'b1;
                        r_state  <= S_IDLE;
                    end
                end
`endif
                default: begin
                    r_ready <= 1'b1;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign ready_o  = r_ready;
    assign valid_o  = r_valid;
    assign result_o = r_result;
    assign zero_o   = r_zero;
endmodule

// File: tb/tb_alu_mc.sv
// Scoreboard bench for alu_mc: a 32-bit and an 8-bit instance driven with directed vectors.
module tb_alu_mc;
    typedef struct {
        logic [31:0] res;
        logic        zero;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;
    exp_t        q32[$];
    exp_t        q8[$];

    logic        valid_i = 1'b0;
    logic [31:0] src1_i = '0;
    logic [31:0] src2_i = '0;
    logic [3:0]  ctrl_i = '0;
    logic        ready_o, valid_o, zero_o;
    logic [31:0] result_o;

    logic        valid8_i = 1'b0;
    logic [7:0]  src18_i = '0;
    logic [7:0]  src28_i = '0;
    logic [3:0]  ctrl8_i = '0;
    logic        ready8_o, valid8_o, zero8_o;
    logic [7:0]  result8_o;

    alu_mc #(.WIDTH(32)) dut (
        .clk_i(clk), .rst_i(rst), .valid_i(valid_i), .ready_o(ready_o),
        .src1_i(src1_i), .src2_i(src2_i), .ctrl_i(ctrl_i),
        .valid_o(valid_o), .result_o(result_o), .zero_o(zero_o)
    );

    alu_mc #(.WIDTH(8)) dut8 (
        .clk_i(clk), .rst_i(rst), .valid_i(valid8_i), .ready_o(ready8_o),
        .src1_i(src18_i), .src2_i(src28_i), .ctrl_i(ctrl8_i),
        .valid_o(valid8_o), .result_o(result8_o), .zero_o(zero8_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, req, cyc);
        end else begin
            $display("ok   %s: 0x%08h (cycle %0d)", name, act, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (valid_o === 1'b1) begin
            if (q32.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_valid32: got result 0x%08h expected no output", result_o);
            end else begin
                exp_t e;
                e = q32.pop_front();
                check("result32", result_o, e.res);
                check("zero32", {31'd0, zero_o}, {31'd0, e.zero});
                check("latency32", cyc, e.cyc);
            end
        end
        if (valid8_o === 1'b1) begin
            if (q8.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_valid8: got result 0x%02h expected no output", result8_o);
            end else begin
                exp_t e;
                e = q8.pop_front();
                check("result8", {24'd0, result8_o}, e.res);
                check("zero8", {31'd0, zero8_o}, {31'd0, e.zero});
                check("latency8", cyc, e.cyc);
            end
        end
    end

    // Issues one op once ready; pushes the expected result due lat cycles after acceptance.
    task automatic issue32(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp_res, input int lat, input bit push);
        int guard = 0;
        @(negedge clk);
        while (ready_o !== 1'b1 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 100) begin
            total++;
            bad++;
            $display("FAIL ready_timeout32: got ready_o=%b expected 1", ready_o);
        end
        valid_i = 1'b1;
        ctrl_i  = op;
        src1_i  = a;
        src2_i  = b;
        @(posedge clk);
        #1;
        if (push) q32.push_back('{exp_res, (exp_res == 32'd0), cyc + lat - 1});
        valid_i = 1'b0;
    endtask

    task automatic issue8(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] exp_res, input int lat);
        int guard = 0;
        @(negedge clk);
        while (ready8_o !== 1'b1 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 100) begin
            total++;
            bad++;
            $display("FAIL ready_timeout8: got ready_o=%b expected 1", ready8_o);
        end
        valid8_i = 1'b1;
        ctrl8_i  = op;
        src18_i  = a;
        src28_i  = b;
        @(posedge clk);
        #1;
        q8.push_back('{{24'd0, exp_res}, (exp_res == 8'd0), cyc + lat - 1});
        valid8_i = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_ready", {31'd0, ready_o}, 32'd1);
        check("rst_valid", {31'd0, valid_o}, 32'd0);
        check("rst_result", result_o, 32'd0);
        check("rst_zero", {31'd0, zero_o}, 32'd1);

        // Single-cycle class, issued back to back
        issue32(4'd3, 32'd5, 32'd5, 32'd0, 1, 1);
        issue32(4'd2, 32'hFFFFFFFF, 32'd1, 32'd0, 1, 1);
        issue32(4'd0, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1, 1);
        issue32(4'd1, 32'h0000000F, 32'h000000F0, 32'h000000FF, 1, 1);
        issue32(4'd7, 32'hFFFFFFFF, 32'd1, 32'd1, 1, 1);
        issue32(4'd4, 32'hFFFFFFFF, 32'd1, 32'd0, 1, 1);
        issue32(4'd5, 32'd32, 32'hFFFFFFFF, 32'd0, 1, 1);
        issue32(4'd5, 32'd4, 32'h80000000, 32'h08000000, 1, 1);
        issue32(4'd6, 32'd31, 32'd1, 32'h80000000, 1, 1);
        issue32(4'd14, 32'd0, 32'h00001234, 32'h12340000, 1, 1);
        issue32(4'd15, 32'd1, 32'd2, 32'd0, 1, 1);

        // MUL with ignored requests and changing inputs while busy
        issue32(4'd8, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFA, 33, 1);
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            check("busy_ready", {31'd0, ready_o}, 32'd0);
            valid_i = (i % 3 == 0) ? 1'b1 : 1'b0;
            src1_i  = $urandom;
            src2_i  = $urandom;
            ctrl_i  = 4'd2;
        end
        valid_i = 1'b0;
        @(negedge clk);
        check("ready_after_mul", {31'd0, ready_o}, 32'd1);

        // Reset aborts a MUL in flight at iteration 10
        issue32(4'd8, 32'd7, 32'd9, 32'd0, 0, 0);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("abort_result", result_o, 32'd0);
        check("abort_ready", {31'd0, ready_o}, 32'd1);
        check("abort_valid", {31'd0, valid_o}, 32'd0);
        repeat (40) @(negedge clk);
        issue32(4'd2, 32'd2, 32'd3, 32'd5, 1, 1);

`ifdef ALU_MC_DIV_EN
        issue32(4'd9, 32'd100, 32'd7, 32'd14, 33, 1);
        issue32(4'd10, 32'd100, 32'd7, 32'd2, 33, 1);
        issue32(4'd9, 32'd5, 32'd0, 32'hFFFFFFFF, 33, 1);
        issue32(4'd10, 32'd5, 32'd0, 32'd5, 33, 1);
`else
        issue32(4'd9, 32'd100, 32'd7, 32'd0, 1, 1);
        issue32(4'd10, 32'd100, 32'd7, 32'd0, 1, 1);
`endif
        issue32(4'd8, 32'd7, 32'd9, 32'd63, 33, 1);

        // WIDTH=8 instance
        issue8(4'd8, 8'h10, 8'h10, 8'h00, 9);
        issue8(4'd6, 8'd8, 8'hFF, 8'h00, 1);
        issue8(4'd8, 8'h0F, 8'h11, 8'hFF, 9);
        issue8(4'd14, 8'd0, 8'h0A, 8'hA0, 1);

        begin
            int g = 0;
            while ((q32.size() != 0 || q8.size() != 0) && g < 200) begin
                @(negedge clk);
                g++;
            end
            if (q32.size() != 0 || q8.size() != 0) begin
                total++;
                bad++;
                $display("FAIL drain_timeout: got %0d pending expected 0", q32.size() + q8.size());
            end
        end
        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/alu_mc.md
# alu_mc

Parametrised multi-cycle ALU for the pipelined/multi-cycle CPU datapath. It extends the single-cycle ALU operation set with a configurable datapath width, a registered valid/ready handshake, and an iterative shift-add multiplier. An optional iterative unsigned divider is compiled in by macro. It sits in the EX stage; the controller stalls issue while `ready_o` is low.

## Interface
- `WIDTH`, 32: datapath width in bits; even, ≥ 8.
- `CNT_W`, $clog2(WIDTH)+1: iteration counter width; derived, not overridden.

- `clk_i`  in  1  clock; all state changes on the rising edge.
- `rst_i`  in  1  reset, synchronous, active-high.
- `valid_i`  in  1  operation request.
- `ready_o`  out  1  block can accept; high only in IDLE.
- `src1_i`  in  WIDTH  operand 1; shift amount for shifts.
- `src2_i`  in  WIDTH  operand 2; shifted value for shifts.
- `ctrl_i`  in  4  operation code.
- `valid_o`  out  1  one-cycle pulse; `result_o`/`zero_o` are new.
- `result_o`  out  WIDTH  registered result, held until the next result.
- `zero_o`  out  1  registered; equals (`result_o` == 0).

## Operation
- Accept: `valid_i && ready_o` at a rising edge. `src1_i`, `src2_i` and `ctrl_i` are captured at that edge; later input changes have no effect. `valid_i` is ignored while `ready_o` is low.
- Operation codes, single-cycle class:
  - 0: AND.
  - 1: OR.
  - 2: ADD, modulo 2^WIDTH.
  - 3: SUB, modulo 2^WIDTH.
  - 4: SLTU. Result is 1 or 0, zero-extended.
  - 5: SRL, src2 >> src1.
  - 6: SLL, src2 << src1.
  - 7: SLT (signed). Result is 1 or 0, zero-extended.
  - 14: LUI, src2 << (WIDTH/2).
- Shift amount is the full unsigned `src1`; any amount ≥ WIDTH gives 0.
- Code 8 MUL, multi-cycle class:
  - Iterative shift-add over `src2` bits, one bit per cycle, WIDTH iterations.
  - Result is the low WIDTH bits of the product. The same bits are correct for signed and unsigned operands.
- Undefined codes: single-cycle class; `result_o` = 0, `zero_o` = 1.
- FSM states: IDLE, MUL, DIV (DIV exists only with the macro).
  - IDLE → IDLE on accepting a single-cycle op; result is registered at that edge.
  - IDLE → MUL/DIV on accepting a multi-cycle op; counter loads WIDTH.
  - MUL/DIV: counter decrements once per edge. The edge where the counter goes 1→0 writes the result, pulses `valid_o`, and returns to IDLE.
- Back-to-back: `ready_o` is high in the same cycle as `valid_o`, so a new op can be accepted on the edge following completion.
- Reset: `rst_i` high at an edge aborts any operation in flight and discards it. Reset values:
  - state = IDLE
  - `ready_o` = 1
  - `valid_o` = 0
  - `result_o` = 0
  - `zero_o` = 1

## Timing
- Single-cycle ops: accepted at edge E; `valid_o` is high in the cycle after E (latency 1). Throughput is one op per cycle.
- MUL/DIV: accepted at edge E; `ready_o` is low from E to E+WIDTH. `valid_o` is high in the cycle after edge E+WIDTH (latency WIDTH+1). `ready_o` goes high again in that same cycle.
- `valid_o` is a one-cycle pulse, with no output backpressure. `result_o` and `zero_o` change only on edges where `valid_o` is set.
- Simultaneous `rst_i` and `valid_i`: reset wins and nothing is accepted.

## Configuration
- `ALU_MC_DIV_EN` defined:
  - Code 9 DIVU gives the unsigned quotient.
  - Code 10 REMU gives the unsigned remainder.
  - Both use restoring division, one quotient bit per cycle, in state DIV, with MUL latency.
  - Divide by zero: quotient = all ones, remainder = `src1`, same latency.
- `ALU_MC_DIV_EN` undefined:
  - The DIV state and divider datapath are absent.
  - Codes 9 and 10 behave as undefined codes (latency 1, result 0, `zero_o` 1).

## Test plan
- Reset, then accept SUB 5−5 (WIDTH=32) → `valid_o` one cycle later, `result_o`=0, `zero_o`=1; ADD 0xFFFFFFFF+1 in the next cycle → 0, `zero_o`=1.
- SLT 0xFFFFFFFF vs 1 → 1; SLTU with the same operands → 0; SRL src1=32, src2=0xFFFFFFFF → 0; LUI src2=0x1234 → 0x12340000.
- MUL 0xFFFFFFFE × 3 → `ready_o` low 32 cycles, `valid_o` at cycle 33, `result_o`=0xFFFFFFFA; `valid_i` pulses while busy are ignored.
- Start MUL 7×9, assert `rst_i` at iteration 10 → no `valid_o`, `result_o`=0, `ready_o`=1; a following ADD 2+3 gives 5 at latency 1.
- With `ALU_MC_DIV_EN`: DIVU 100/7 → 14, REMU 100/7 → 2, DIVU 5/0 → 0xFFFFFFFF, REMU 5/0 → 5, each at latency 33. Without it: code 9 → 0 at latency 1.
- WIDTH=8: MUL 0x10×0x10 → 0x00, `zero_o`=1, latency 9; SLL src1=8 → 0.
